// File: rtl/sram2p_pkg.sv
// Shared constants and helpers for the sram2p front-end arbiter.
package sram2p_pkg;

    // Requester identifiers as carried through the tracking pipe and FIFO
    localparam logic RD0 = 1'b0;
    localparam logic RD1 = 1'b1;

    // Round-robin pointer: which read requester wins a tie next
    typedef enum logic {
        RR_RD0 = 1'b0,
        RR_RD1 = 1'b1
    } rr_ptr_e;

    // Cycles from read issue to data on mem_read_data
    function automatic int unsigned rd_latency(input int unsigned nbpipe);
        return nbpipe + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, no bypass: data written in cycle t is visible from t+1.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(wr_en) - CW'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (cnt == '0);
    assign count   = cnt;

endmodule

// File: rtl/sram2p_arbiter.sv
// Shares one sram2p between two read requesters and one write requester.
// Reads are tracked through the SRAM's fixed latency and land in a
// credit-protected response FIFO so the SRAM can never overrun it.
module sram2p_arbiter
    import sram2p_pkg::*;
#(
    parameter int unsigned AWIDTH    = 12,
    parameter int unsigned DWIDTH    = 72,
    parameter int unsigned NBPIPE    = 3,
    parameter int unsigned RSP_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd0_valid,
    output logic              rd0_ready,
    input  logic [AWIDTH-1:0] rd0_addr,
    input  logic              rd1_valid,
    output logic              rd1_ready,
    input  logic [AWIDTH-1:0] rd1_addr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              mem_enable,
    output logic              write_enable,
    output logic [AWIDTH-1:0] mem_write_address,
    output logic [AWIDTH-1:0] mem_read_address,
    output logic [DWIDTH-1:0] mem_write_data,
    input  logic [DWIDTH-1:0] mem_read_data
);

    localparam int unsigned L  = rd_latency(NBPIPE);
    localparam int unsigned CW = $clog2(RSP_DEPTH+1);

    rr_ptr_e         rr_q;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;
    logic            credit_ok;
    logic            pick_rd1;
    logic            rd_grant;
    logic            grant_id;
    logic            wr_accept;
    logic            pipe_vld [L];
    logic            pipe_id  [L];
    logic            fifo_wr;
    logic            fifo_rd;
    logic            fifo_empty;
    logic [DWIDTH:0] fifo_head;

    // A pop in the current cycle does not free credit until the next one
    assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign credit_ok = (occupancy < (CW+1)'(RSP_DEPTH));

    // Read arbitration and SRAM request muxing
    always_comb begin
        pick_rd1 = 1'b0;
        if (rd0_valid && rd1_valid) begin
            pick_rd1 = (rr_q == RR_RD1);
        end else begin
            pick_rd1 = rd1_valid;
        end
        rd_grant          = rst_n & (rd0_valid | rd1_valid) & credit_ok;
        grant_id          = pick_rd1 ? RD1 : RD0;
        rd0_ready         = rd_grant & ~pick_rd1;
        rd1_ready         = rd_grant & pick_rd1;
        wr_accept         = rst_n & wr_valid;
        wr_ready          = rst_n;
        mem_enable        = rd_grant | wr_accept;
        write_enable      = wr_accept;
        mem_read_address  = pick_rd1 ? rd1_addr : rd0_addr;
        mem_write_address = wr_addr;
        mem_write_data    = wr_data;
    end

    // Round-robin pointer flips to the other requester after every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= RR_RD0;
        end else if (rd_grant) begin
            rr_q <= (grant_id == RD0) ? RR_RD1 : RR_RD0;
        end
    end

    // Tracking pipe: stage L-1 lines up with the data on mem_read_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < L; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_id[i]  <= 1'b0;
            end
        end else begin
            pipe_vld[0] <= rd_grant;
            pipe_id[0]  <= grant_id;
            for (int unsigned i = 1; i < L; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    assign fifo_wr = pipe_vld[L-1];
    assign fifo_rd = rsp_ready & ~fifo_empty;

    // Reads issued but not yet written into the response FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_q + CW'(rd_grant) - CW'(fifo_wr);
        end
    end

    sync_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data ({pipe_id[L-1], mem_read_data}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rsp_valid = ~fifo_empty;
    assign rsp_id    = fifo_head[DWIDTH];
    assign rsp_data  = fifo_head[DWIDTH-1:0];

endmodule

// File: tb/tb_sram2p_arbiter.sv
// Bench for sram2p_arbiter with a behavioural sram2p and a response scoreboard.
module tb_sram2p_arbiter;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 72;
    localparam int unsigned NBP   = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned L     = NBP + 1;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int unsigned   cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd0_valid, rd0_ready, rd1_valid, rd1_ready;
    logic [AW-1:0] rd0_addr, rd1_addr;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [DW-1:0] rsp_data;
    logic          mem_enable, write_enable;
    logic [AW-1:0] mem_write_address, mem_read_address;
    logic [DW-1:0] mem_write_data, mem_read_data;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;
    int unsigned cyc      = 0;
    int unsigned grant_cnt = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    sram2p_arbiter #(
        .AWIDTH    (AW),
        .DWIDTH    (DW),
        .NBPIPE    (NBP),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rd0_valid         (rd0_valid),
        .rd0_ready         (rd0_ready),
        .rd0_addr          (rd0_addr),
        .rd1_valid         (rd1_valid),
        .rd1_ready         (rd1_ready),
        .rd1_addr          (rd1_addr),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_id            (rsp_id),
        .rsp_data          (rsp_data),
        .mem_enable        (mem_enable),
        .write_enable      (write_enable),
        .mem_write_address (mem_write_address),
        .mem_read_address  (mem_read_address),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data)
    );

    function automatic logic [DW-1:0] init_val(input int unsigned a);
        logic [AW-1:0] x;
        x = AW'(a) ^ 12'h5A5;
        return {6{x}};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural sram2p: read-before-write, L-cycle read latency, unreset pipe
    logic [DW-1:0] sram [4096];
    logic [DW-1:0] spipe [L];
    logic          sram_init = 1'b0;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 4096; i++) sram[i] <= init_val(i);
            sram_init <= 1'b1;
        end else if (mem_enable && write_enable) begin
            sram[mem_write_address] <= mem_write_data;
        end
        if (mem_enable) spipe[0] <= sram[mem_read_address];
        for (int i = 1; i < L; i++) spipe[i] <= spipe[i-1];
    end
    assign mem_read_data = spipe[L-1];

    // Reference model and scoreboard, sampled mid-cycle
    logic [DW-1:0] ref_mem [4096];
    logic          ref_init = 1'b0;
    logic          m_rr = 1'b0;
    logic          g0, g1, exp_v;
    exp_t          e;
    always @(negedge clk) begin
        cyc++;
        if (!ref_init) begin
            for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
            ref_init = 1'b1;
        end
        if (!rst_n) begin
            sb.delete();
            m_rr = 1'b0;
            check_eq("rst_rd0_ready", rd0_ready, 0);
            check_eq("rst_rd1_ready", rd1_ready, 0);
            check_eq("rst_wr_ready", wr_ready, 0);
            check_eq("rst_mem_enable", mem_enable, 0);
            check_eq("rst_write_enable", write_enable, 0);
            check_eq("rst_rsp_valid", rsp_valid, 0);
        end else begin
            g0 = 1'b0;
            g1 = 1'b0;
            if (sb.size() < DEPTH) begin
                if (rd0_valid && rd1_valid) begin
                    if (m_rr) g1 = 1'b1; else g0 = 1'b1;
                end else if (rd0_valid) begin
                    g0 = 1'b1;
                end else if (rd1_valid) begin
                    g1 = 1'b1;
                end
            end
            check_eq("rd0_ready", rd0_ready, g0);
            check_eq("rd1_ready", rd1_ready, g1);
            check_eq("wr_ready", wr_ready, 1);
            check_eq("mem_enable", mem_enable, g0 | g1 | wr_valid);
            check_eq("write_enable", write_enable, wr_valid);
            if (g0 || g1)
                check_eq("mem_read_address", mem_read_address, g1 ? rd1_addr : rd0_addr);
            exp_v = (sb.size() != 0) && (cyc >= sb[0].cyc + L + 1);
            check_eq("rsp_valid", rsp_valid, exp_v);
            if (rsp_valid && exp_v) begin
                check_eq("rsp_id", rsp_id, sb[0].id);
                check_eq("rsp_data", rsp_data, sb[0].data);
                if (rsp_ready) void'(sb.pop_front());
            end
            if (g0 || g1) begin
                e.id   = g1;
                e.data = ref_mem[g1 ? rd1_addr : rd0_addr];
                e.cyc  = cyc;
                sb.push_back(e);
                m_rr = g0;
                grant_cnt++;
            end
            if (wr_valid) ref_mem[wr_addr] = wr_data;
        end
    end

    task automatic step(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        rd0_valid = 1'b0;
        rd1_valid = 1'b0;
        wr_valid  = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        idle_inputs();
        rsp_ready = 1'b1;
        while (sb.size() != 0 && n < 60) begin
            step();
            n++;
        end
        check_eq("drain_empty", 128'(sb.size()), 0);
    endtask

    initial begin
        int unsigned base;
        rst_n = 1'b0;
        idle_inputs();
        rd0_addr = '0; rd1_addr = '0; wr_addr = '0; wr_data = '0;
        rsp_ready = 1'b1;
        step(3);
        rst_n = 1'b1;

        // write then read-after-write
        wr_valid = 1'b1; wr_addr = 12'd5; wr_data = 72'h12;
        step();
        wr_valid = 1'b0;
        rd0_valid = 1'b1; rd0_addr = 12'd5;
        step();
        drain();

        // both readers continuously valid
        rd0_valid = 1'b1; rd1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rd0_addr = AW'($urandom_range(0, 4095));
            rd1_addr = AW'($urandom_range(0, 4095));
            step();
        end
        drain();

        // same-cycle write/read collision, then read one cycle later
        wr_valid = 1'b1; wr_addr = 12'd9; wr_data = 72'h55;
        step();
        wr_data = 72'hAA;
        rd0_valid = 1'b1; rd0_addr = 12'd9;
        step();
        wr_valid = 1'b0; rd0_valid = 1'b0;
        rd1_valid = 1'b1; rd1_addr = 12'd9;
        step();
        drain();

        // write-only traffic
        wr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_addr = AW'($urandom_range(0, 4095));
            wr_data = {$urandom(), $urandom(), 8'($urandom())};
            step();
        end
        drain();
        step(3);

        // credit exhaustion with a stalled consumer, then a single pop
        base = grant_cnt;
        rsp_ready = 1'b0;
        rd0_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            rd0_addr = AW'($urandom_range(0, 4095));
            step();
        end
        check_eq("credit_fill_grants", 128'(grant_cnt - base), 8);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step(6);
        check_eq("credit_one_pop_grants", 128'(grant_cnt - base), 9);
        drain();

        // reset with reads in flight and responses queued
        rsp_ready = 1'b0;
        rd0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd0_addr = AW'($urandom_range(0, 4095));
            step();
        end
        rd0_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step(10);
        base = grant_cnt;
        rsp_ready = 1'b0;
        rd0_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rd0_addr = AW'($urandom_range(0, 4095));
            step();
        end
        check_eq("post_reset_credit", 128'(grant_cnt - base), 8);
        drain();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
